// File: rtl/wave_capture.sv
// Triggered single-channel capture buffer for a VGA scope display.
// Arms on mode/button, captures DEPTH samples after a rising threshold crossing, then holds for readout.
module wave_capture #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 200,
  parameter int ADDR_W = 8,
  parameter int WIN_X0 = 100,
  parameter int WIN_Y0 = 200,
  parameter int WIN_H  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [1:0]        mode,
  input  logic              sw_single,
  input  logic [9:0]        value_x,
  input  logic [9:0]        value_y,
  input  logic [DATA_W-1:0] live_data,
  output logic [DATA_W-1:0] vga_data,
  output logic [1:0]        state_o,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [1:0]        MODE_LIVE   = 2'd0;
  localparam logic [1:0]        MODE_NORMAL = 2'd1;
  localparam logic [1:0]        MODE_SINGLE = 2'd2;
  localparam logic [1:0]        MODE_STOP   = 2'd3;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_prev_sample;
  logic              r_sw_meta;
  logic              r_sw_sync;
  logic              r_sw_last;
  logic              r_done;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_live_d1;
  logic [DATA_W-1:0] r_vga;
  logic              r_in_win_d1;

  logic              w_arm;
  logic              w_trig;
  logic              w_abort;
  logic              w_rearm;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic              w_in_win;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [31:0]       w_x;
  logic [31:0]       w_y;

  // sample_valid is a single-cycle qualifier with no backpressure: a sample is
  // consumed on every clock where sample_valid is high, and ignored otherwise.
  assign w_arm   = r_sw_sync & ~r_sw_last;
  assign w_trig  = sample_valid && (r_prev_sample < trig_level) && (sample >= trig_level);
  assign w_abort = (mode == MODE_LIVE) || (mode == MODE_STOP);
  assign w_rearm = (mode == MODE_NORMAL) || ((mode == MODE_SINGLE) && w_arm);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_wr_addr;
    if (!rst && !w_abort) begin
      if ((r_state == ARMED) && w_trig) begin
        w_we    = 1'b1;
        w_waddr = '0;
      end else if ((r_state == CAPTURE) && sample_valid) begin
        w_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_meta     <= 1'b0;
      r_sw_sync     <= 1'b0;
      r_sw_last     <= 1'b0;
      r_prev_sample <= '0;
    end else begin
      r_sw_meta <= sw_single;
      r_sw_sync <= r_sw_meta;
      r_sw_last <= r_sw_sync;
      if (sample_valid) r_prev_sample <= sample;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wr_addr <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rearm) r_state <= ARMED;
        end
        ARMED: begin
          if (mode == MODE_LIVE) begin
            r_state <= IDLE;
          end else if (mode == MODE_STOP) begin
            r_state <= HOLD;
          end else if (w_trig) begin
            // Address 0 is taken by the triggering sample itself.
            r_state   <= CAPTURE;
            r_wr_addr <= ADDR_W'(1);
          end
        end
        CAPTURE: begin
          if (mode == MODE_LIVE) begin
            r_state <= IDLE;
          end else if (mode == MODE_STOP) begin
            r_state <= HOLD;
          end else if (sample_valid) begin
            if (r_wr_addr == LAST_ADDR) begin
              r_done  <= 1'b1;
              r_state <= HOLD;
            end else begin
              r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
          end
        end
        HOLD: begin
          if (w_rearm) r_state <= ARMED;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_x      = 32'(value_x);
  assign w_y      = 32'(value_y);
  assign w_in_win = (w_x >= 32'(WIN_X0)) && (w_x < 32'(WIN_X0 + DEPTH)) &&
                    (w_y >= 32'(WIN_Y0)) && (w_y < 32'(WIN_Y0 + WIN_H));
  assign w_rd_addr = w_in_win ? ADDR_W'(w_x - 32'(WIN_X0)) : r_rd_addr;

  // Read-before-write RAM: a same-address read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= sample;
    r_q <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr   <= '0;
      r_in_win_d1 <= 1'b0;
      r_live_d1   <= '0;
      r_vga       <= '0;
    end else begin
      r_rd_addr   <= w_rd_addr;
      r_in_win_d1 <= w_in_win;
      r_live_d1   <= live_data;
      r_vga       <= ((mode != MODE_LIVE) && (r_state == HOLD) && r_in_win_d1) ? r_q : r_live_d1;
    end
  end

  assign vga_data = r_vga;
  assign state_o  = r_state;
  assign done     = r_done;

endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the capture/display rules.
module tb_wave_capture;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 200;
  localparam int WIN_X0 = 100;
  localparam int WIN_Y0 = 200;
  localparam int WIN_H  = 256;
  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_HOLD = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] trig_level;
  logic [1:0]        mode;
  logic              sw_single;
  logic [9:0]        value_x;
  logic [9:0]        value_y;
  logic [DATA_W-1:0] live_data;
  logic [DATA_W-1:0] vga_data;
  logic [1:0]        state_o;
  logic              done;

  wave_capture dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig_level   (trig_level),
    .mode         (mode),
    .sw_single    (sw_single),
    .value_x      (value_x),
    .value_y      (value_y),
    .live_data    (live_data),
    .vga_data     (vga_data),
    .state_o      (state_o),
    .done         (done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state, m_cnt, m_prev;
  bit m_h1, m_h2, m_h3;
  int m_mem [DEPTH];
  bit m_known [DEPTH];
  bit m_win_prev, m_rd_ok_prev;
  int m_rd_prev, m_live_prev;
  int e_state, e_done, e_vga;
  bit e_vga_ok;
  int n_done_seen = 0;
  int n_done_exp  = 0;

  task automatic model_edge();
    bit arm, trig, inwin;
    int addr;
    if (rst) begin
      e_vga = 0; e_vga_ok = 1; e_done = 0;
      m_state = S_IDLE; m_cnt = 0; m_prev = 0;
      m_h1 = 0; m_h2 = 0; m_h3 = 0;
      m_win_prev = 0; m_live_prev = 0; m_rd_ok_prev = 0; m_rd_prev = 0;
      e_state = m_state;
      return;
    end
    if (mode != 2'd0 && m_state == S_HOLD && m_win_prev) begin
      e_vga = m_rd_prev; e_vga_ok = m_rd_ok_prev;
    end else begin
      e_vga = m_live_prev; e_vga_ok = 1;
    end
    inwin = (value_x >= WIN_X0) && (value_x < WIN_X0 + DEPTH) &&
            (value_y >= WIN_Y0) && (value_y < WIN_Y0 + WIN_H);
    if (inwin) begin
      addr = int'(value_x) - WIN_X0;
      m_rd_prev = m_mem[addr];
      m_rd_ok_prev = m_known[addr];
    end
    m_win_prev = inwin;
    m_live_prev = int'(live_data);
    // button seen two edges late; event is a 0->1 of that delayed copy
    arm = m_h2 && !m_h3;
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = sw_single;
    trig = sample_valid && (m_prev < int'(trig_level)) && (sample >= trig_level);
    if (sample_valid) m_prev = int'(sample);
    e_done = 0;
    if (m_state == S_IDLE || m_state == S_HOLD) begin
      if (mode == 2'd1 || (mode == 2'd2 && arm)) m_state = S_ARMED;
    end else if (mode == 2'd0) begin
      m_state = S_IDLE;
    end else if (mode == 2'd3) begin
      m_state = S_HOLD;
    end else if (m_state == S_ARMED) begin
      if (trig) begin
        m_mem[0] = int'(sample); m_known[0] = 1;
        m_cnt = 1; m_state = S_CAPTURE;
      end
    end else if (sample_valid) begin
      m_mem[m_cnt] = int'(sample); m_known[m_cnt] = 1;
      m_cnt++;
      if (m_cnt == DEPTH) begin
        e_done = 1; m_state = S_HOLD;
      end
    end
    e_state = m_state;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    live_data = DATA_W'($urandom_range(0, 255));
    model_edge();
    @(posedge clk); #1;
    check("state", int'(state_o), e_state);
    check("done", int'(done), e_done);
    if (done) n_done_seen++;
    if (e_done != 0) n_done_exp++;
    if (e_vga_ok) check("vga", int'(vga_data), e_vga);
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0; sample = '0; sw_single = 1'b0;
    value_x = '0; value_y = '0;
    step(); step();
    rst = 1'b0;
    check("rst_state", int'(state_o), 0);
    check("rst_vga", int'(vga_data), 0);
    check("rst_done", int'(done), 0);
  endtask

  // ramp with a button pulse; stops once the model has written stop_cnt samples
  task automatic ramp_until(input int stop_cnt);
    for (int i = 0; i < 1000; i++) begin
      sample = DATA_W'(i);
      sample_valid = 1'b1;
      sw_single = (i >= 2 && i < 4);
      step();
      if (m_state == S_CAPTURE && m_cnt == stop_cnt) break;
      if (m_state == S_HOLD) break;
    end
    sw_single = 1'b0;
  endtask

  task automatic read_back(input int n);
    sample_valid = 1'b0;
    value_y = 10'd300;
    for (int j = 0; j <= n; j++) begin
      if (j < n) begin
        value_x = 10'(WIN_X0 + j);
        exp_q.push_back(DATA_W'((128 + j) % 256));
      end else begin
        value_x = 10'd0;
      end
      step();
      if (j >= 1) check("readout", int'(vga_data), int'(exp_q.pop_front()));
    end
  endtask

  function automatic int sine_val(input int p);
    int t, v;
    t = p % 32;
    v = t * (32 - t) / 2;
    return ((p % 64) < 32) ? 127 + v : 128 - v;
  endfunction

  int px [3] = '{99, 300, 150};
  int py [3] = '{300, 300, 199};
  int d0, arm_entries, prev_st, hold_run, max_run, phase;
  logic [DATA_W-1:0] l_hold;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; mode = 2'd0; trig_level = 8'd128; live_data = '0;
    sample_valid = 1'b0; sample = '0; sw_single = 1'b0; value_x = '0; value_y = '0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    do_reset();

    // single-shot ramp capture and full readout
    mode = 2'd2; trig_level = 8'd128;
    ramp_until(DEPTH + 1);
    check("ramp_hold", int'(state_o), S_HOLD);
    read_back(DEPTH);

    // pixels outside the window while holding show delayed live data
    for (int j = 0; j < 3; j++) begin
      value_x = 10'(px[j]); value_y = 10'(py[j]);
      step();
      l_hold = live_data;
      step();
      check("outside_live", int'(vga_data), int'(l_hold));
    end

    // stop mode mid-capture
    do_reset();
    mode = 2'd2; d0 = n_done_seen;
    ramp_until(50);
    mode = 2'd3;
    step();
    check("stop_hold", int'(state_o), S_HOLD);
    read_back(50);
    check("stop_no_done", n_done_seen - d0, 0);

    // reset mid-capture
    do_reset();
    mode = 2'd2;
    ramp_until(10);
    rst = 1'b1;
    step();
    check("rst_mid_state", int'(state_o), 0);
    check("rst_mid_vga", int'(vga_data), 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin sample = DATA_W'(i * 13); step(); end
    check("rst_stay_idle", int'(state_o), S_IDLE);

    // button glitch: one arm on the rise, none on the fall
    do_reset();
    sample_valid = 1'b0;
    mode = 2'd1; step();
    mode = 2'd3; step();
    check("glitch_pre_hold", int'(state_o), S_HOLD);
    mode = 2'd2; arm_entries = 0; prev_st = int'(state_o);
    for (int i = 0; i < 12; i++) begin
      sw_single = (i < 5);
      step();
      if (state_o == 2'd1 && prev_st != S_ARMED) arm_entries++;
      prev_st = int'(state_o);
    end
    check("glitch_arm_count", arm_entries, 1);
    check("glitch_armed", int'(state_o), S_ARMED);
    mode = 2'd3; sw_single = 1'b1;
    for (int i = 0; i < 6; i++) step();
    mode = 2'd2;
    for (int i = 0; i < 4; i++) step();
    sw_single = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("fall_no_rearm", int'(state_o), S_HOLD);

    // normal mode with a sine input: repeated captures, one-cycle re-arm
    do_reset();
    mode = 2'd1; trig_level = 8'd128; phase = 0;
    d0 = n_done_seen; hold_run = 0; max_run = 0;
    value_x = 10'd150; value_y = 10'd300;
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      sample = DATA_W'(sine_val(phase));
      if (sample_valid) phase++;
      step();
      if (state_o == 2'd3) hold_run++;
      else begin
        if (hold_run > max_run) max_run = hold_run;
        hold_run = 0;
      end
    end
    check("sine_multi", (n_done_seen - d0 >= 3) ? 1 : 0, 1);
    check("sine_hold_len", max_run, 1);
    check("done_total", n_done_seen, n_done_exp);

    // random traffic
    do_reset();
    mode = 2'd1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) sw_single = ~sw_single;
      if ($urandom_range(0, 99) == 0) trig_level = DATA_W'($urandom_range(0, 255));
      sample_valid = 1'($urandom_range(0, 1));
      sample = DATA_W'($urandom_range(0, 255));
      value_x = 10'($urandom_range(80, 320));
      value_y = 10'($urandom_range(190, 470));
      step();
    end
    check("done_total_rand", n_done_seen, n_done_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
